instr_fetch_ctrl: RTL and testbench
===================================

# instr_fetch_ctrl

Fetch sequencer for the single-cycle-read instruction memory. Owns the fetch program counter, drives the memory's word address, and buffers each fetched word together with its PC in a 2-entry prefetch queue. The queue feeds the decode stage over a valid/ready handshake. It also handles control-flow redirects from execute and stops fetching on a halt instruction.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC loaded at reset
- HALT_WORD, 32'h0000_000C, instruction encoding that stops fetching (syscall)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- run  in  1  fetch enable
- imem_addr  out  32  byte address to instruction memory; combinational copy of fetch PC
- imem_instr  in  32  instruction memory read data, valid in the same cycle as imem_addr
- redirect_valid  in  1  one-cycle pulse: discard buffered fetches and restart at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored and forced to 0
- if_valid  out  1  queue head holds a valid instruction
- if_ready  in  1  decode accepts the head this cycle
- if_instr  out  32  head instruction word
- if_pc  out  32  address of the head instruction
- halted  out  1  high while the FSM is in HALT

## Operation
- FSM states:
  - IDLE to FETCH when run=1.
  - FETCH to IDLE when run=0.
  - FETCH to HALT when the fetched word equals HALT_WORD.
  - HALT is left only by redirect (to FETCH if run=1, else IDLE) or by reset.
- fetch_go = (state==FETCH) && run && !redirect_valid && (queue count<2 || pop).
- On fetch_go:
  - Push {fetch_pc, imem_instr} into the queue.
  - fetch_pc <= fetch_pc+4. The addition is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- HALT_WORD is fetched but not pushed. fetch_pc stays at the halt word's address.
- Pop = if_valid && if_ready.
  - Push and pop in the same cycle are legal at any count, including full.
  - If the pop empties the queue and a push arrives in the same cycle, the pushed entry becomes head next cycle.
- Redirect has priority over all other events, including run=0, HALT, push and pop:
  - The queue is flushed and no push occurs that cycle.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - A pop requested in the redirect cycle is ignored; decode must treat the head as killed.
- if_instr and if_pc show the head entry when if_valid=1, and 0 when the queue is empty.
- imem_addr = fetch_pc in every state.

## Timing
- Reset values:
  - state=IDLE, fetch_pc=RESET_PC, so imem_addr=RESET_PC.
  - Queue empty: if_valid=0, if_instr=0, if_pc=0.
  - halted=0.
  - Outputs take these values immediately on reset assertion, not at the next edge.
- run rising before edge E0: FETCH entered at E0; first push at E1; if_valid=1 after E1.
- After that, one push per cycle while not back-pressured.
- Sustained throughput is 1 instruction/cycle with if_ready held at 1.
- Redirect sampled at edge E: if_valid=0 after E. The first instruction from the new PC is valid after E+1.
- halted rises after the edge at which HALT_WORD was fetched. Entries already queued still drain normally.

## Configuration
- FETCH_PERF_EN defined adds two outputs, both reset to 0 and wrapping at 2^32:
  - fetch_count[31:0]: counts pushes.
  - stall_count[31:0]: counts cycles with state==FETCH, run=1, no redirect, and fetch blocked by a full queue with no pop.
- FETCH_PERF_EN undefined: both ports and both counters are absent. Behaviour is otherwise identical.

## Test plan
- Reset, then run=1 with if_ready=1 and the standard program image -> consecutive if_valid cycles deliver:
  - if_pc=0, if_instr=2001000A
  - if_pc=4, 20020014
  - if_pc=8, 20030032
  - if_pc=C, then the word at C
- Back-pressure: if_ready=0 from reset with run=1 -> queue fills with PCs 0 and 4. imem_addr holds at 8. The head stays 2001000A. After if_ready=1, the sequence 0,4,8 is delivered with no loss or duplicate.
- Redirect to 0x13 while the queue is full -> if_valid=0 the next cycle, then if_pc=10, if_instr=00220820. Stale PCs 0 and 4 never reappear.
- Image with 0000000C at 0x14 -> PCs 0 through 10 delivered. HALT_WORD is not delivered. halted=1 and imem_addr stays 14. A later redirect to 0 clears halted and fetch resumes at 2001000A.
- Async reset asserted mid-stream, between edges -> if_valid=0 and imem_addr=0 before the next edge. Fetch restarts from 0 after release.
- With FETCH_PERF_EN: if_ready held low for 5 cycles after reaching full -> stall_count=5 and fetch_count=2. Without the macro the bench compiles with the ports omitted.

Source files
------------

// File: rtl/instr_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_ctrl_if
//  Description : Bundle of fetch-controller signals: run control, instruction
//                memory port, redirect input, decode-side valid/ready queue
//                head and halt status.
//                master : the fetch controller
//                slave  : the environment (memory, execute, decode)
//                Macro FETCH_PERF_EN adds fetch_count / stall_count.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_ctrl_if;
    logic        run;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    modport master (
        input  run,
        output imem_addr,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_pc,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc,
        output halted
`ifdef FETCH_PERF_EN
        ,
        output fetch_count,
        output stall_count
`endif
    );

    modport slave (
        output run,
        input  imem_addr,
        output imem_instr,
        output redirect_valid,
        output redirect_pc,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc,
        input  halted
`ifdef FETCH_PERF_EN
        ,
        input  fetch_count,
        input  stall_count
`endif
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_ctrl
//  Description : Fetch sequencer for a single-cycle-read instruction memory.
//                Owns the fetch PC, buffers {pc, instr} in a 2-entry prefetch
//                queue feeding decode, handles redirects and stops on the
//                halt (syscall) encoding.
//  Ports       : clk   - clock, rising edge
//                reset - asynchronous active-high reset
//                bus   - instr_fetch_ctrl_if.master (run, imem port,
//                        redirect, decode handshake, halted)
//  Config      : FETCH_PERF_EN - adds fetch_count / stall_count counters
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'h0000_000C
) (
    input  wire logic             clk,
    input  wire logic             reset,
    instr_fetch_ctrl_if.master    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]  count_q, count_d;
    // Slot 0 is always the head; slot 1 the younger entry.
    logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic [31:0] in0_q, in0_d, in1_q, in1_d;

    logic w_pop;
    logic w_is_halt;
    logic w_fetch_go;
    logic w_push;
    logic w_wr_slot0;
    logic w_unused_redirect_bits;

    // Low address bits are forced to zero, so they are deliberately dropped.
    assign w_unused_redirect_bits = |bus.redirect_pc[1:0];

    // A pop in a redirect cycle is ignored: the head is killed by the flush.
    assign w_pop      = (count_q != 2'd0) && bus.if_ready && !bus.redirect_valid;
    assign w_is_halt  = (bus.imem_instr == HALT_WORD);
    assign w_fetch_go = (state_q == ST_FETCH) && bus.run && !bus.redirect_valid &&
                        ((count_q != 2'd2) || w_pop);
    assign w_push     = w_fetch_go && !w_is_halt;
    // The new entry lands in slot 0 whenever the queue is empty after this pop.
    assign w_wr_slot0 = (count_q == 2'd0) || ((count_q == 2'd1) && w_pop);

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        pc0_d      = pc0_q;
        pc1_d      = pc1_q;
        in0_d      = in0_q;
        in1_d      = in1_q;

        if (bus.redirect_valid) begin
            state_d    = bus.run ? ST_FETCH : ST_IDLE;
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            count_d    = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE:  if (bus.run) state_d = ST_FETCH;
                ST_FETCH: begin
                    if (!bus.run)
                        state_d = ST_IDLE;
                    else if (w_fetch_go && w_is_halt)
                        state_d = ST_HALT;
                end
                ST_HALT:  state_d = ST_HALT;
                default:  state_d = ST_IDLE;
            endcase

            // The halt word is not consumed, so fetch_pc stays on its address.
            if (w_push)
                fetch_pc_d = fetch_pc_q + 32'd4;

            if (w_pop) begin
                pc0_d = pc1_q;
                in0_d = in1_q;
            end

            if (w_push) begin
                if (w_wr_slot0) begin
                    pc0_d = fetch_pc_q;
                    in0_d = bus.imem_instr;
                end else begin
                    pc1_d = fetch_pc_q;
                    in1_d = bus.imem_instr;
                end
            end

            count_d = count_q + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            count_q    <= 2'd0;
            pc0_q      <= 32'd0;
            pc1_q      <= 32'd0;
            in0_q      <= 32'd0;
            in1_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            pc0_q      <= pc0_d;
            pc1_q      <= pc1_d;
            in0_q      <= in0_d;
            in1_q      <= in1_d;
        end
    end

    assign bus.imem_addr = fetch_pc_q;
    assign bus.if_valid  = (count_q != 2'd0);
    assign bus.if_pc     = (count_q != 2'd0) ? pc0_q : 32'd0;
    assign bus.if_instr  = (count_q != 2'd0) ? in0_q : 32'd0;
    assign bus.halted    = (state_q == ST_HALT);

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q;
    logic [31:0] stall_count_q;
    logic        w_stall;

    assign w_stall = (state_q == ST_FETCH) && bus.run && !bus.redirect_valid &&
                     (count_q == 2'd2) && !w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            if (w_push)
                fetch_count_q <= fetch_count_q + 32'd1;
            if (w_stall)
                stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign bus.fetch_count = fetch_count_q;
    assign bus.stall_count = stall_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_ctrl
//  Description : Directed self-checking bench for instr_fetch_ctrl with a
//                small combinational instruction memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [31:0] mem [16];

    instr_fetch_ctrl_if bus ();

    instr_fetch_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Single-cycle-read memory: data follows the address combinationally.
    assign bus.imem_instr = mem[bus.imem_addr[5:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        mem[0]  = 32'h2001_000A;
        mem[1]  = 32'h2002_0014;
        mem[2]  = 32'h2003_0032;
        mem[3]  = 32'h0022_1820;
        mem[4]  = 32'h0022_0820;
        mem[5]  = 32'h0000_000C;
        mem[15] = 32'h3C01_FFFF;

        reset              = 1'b1;
        bus.run            = 1'b0;
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;

        #2;
        chk("rst_valid",  {31'd0, bus.if_valid}, 32'd0);
        chk("rst_instr",  bus.if_instr, 32'd0);
        chk("rst_pc",     bus.if_pc, 32'd0);
        chk("rst_addr",   bus.imem_addr, 32'd0);
        chk("rst_halted", {31'd0, bus.halted}, 32'd0);

        // Straight-line stream with decode always ready
        step();
        reset        = 1'b0;
        bus.run      = 1'b1;
        bus.if_ready = 1'b1;
        step();  // E0: enter FETCH
        chk("e0_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("e0_addr",  bus.imem_addr, 32'd0);
        step();  // E1
        chk("s1_valid", {31'd0, bus.if_valid}, 32'd1);
        chk("s1_pc",    bus.if_pc, 32'h0);
        chk("s1_instr", bus.if_instr, 32'h2001_000A);
        step();
        chk("s2_pc",    bus.if_pc, 32'h4);
        chk("s2_instr", bus.if_instr, 32'h2002_0014);
        step();
        chk("s3_pc",    bus.if_pc, 32'h8);
        chk("s3_instr", bus.if_instr, 32'h2003_0032);
        step();
        chk("s4_pc",    bus.if_pc, 32'hC);
        chk("s4_instr", bus.if_instr, 32'h0022_1820);
        step();
        chk("s5_pc",     bus.if_pc, 32'h10);
        chk("s5_instr",  bus.if_instr, 32'h0022_0820);
        chk("s5_halted", {31'd0, bus.halted}, 32'd0);
        step();  // halt word fetched, not pushed
        chk("h_valid",  {31'd0, bus.if_valid}, 32'd0);
        chk("h_halted", {31'd0, bus.halted}, 32'd1);
        chk("h_addr",   bus.imem_addr, 32'h14);
        step();
        chk("h2_halted", {31'd0, bus.halted}, 32'd1);
        chk("h2_addr",   bus.imem_addr, 32'h14);
        chk("h2_valid",  {31'd0, bus.if_valid}, 32'd0);

        // Redirect out of HALT
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0;
        step();
        bus.redirect_valid = 1'b0;
        chk("rh_halted", {31'd0, bus.halted}, 32'd0);
        chk("rh_valid",  {31'd0, bus.if_valid}, 32'd0);
        chk("rh_addr",   bus.imem_addr, 32'h0);
        step();
        chk("rh2_valid", {31'd0, bus.if_valid}, 32'd1);
        chk("rh2_instr", bus.if_instr, 32'h2001_000A);
        chk("rh2_addr",  bus.imem_addr, 32'h4);

        // Asynchronous reset between edges
        #3;
        reset = 1'b1;
        #1;
        chk("ar_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("ar_addr",  bus.imem_addr, 32'h0);
        chk("ar_pc",    bus.if_pc, 32'h0);

        // Back-pressure from reset
        bus.if_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();  // E0
        step();  // E1
        step();  // E2: queue full
        chk("bp_valid", {31'd0, bus.if_valid}, 32'd1);
        chk("bp_pc",    bus.if_pc, 32'h0);
        chk("bp_addr",  bus.imem_addr, 32'h8);
        for (int i = 0; i < 5; i++) step();
        chk("bp5_pc",    bus.if_pc, 32'h0);
        chk("bp5_instr", bus.if_instr, 32'h2001_000A);
        chk("bp5_addr",  bus.imem_addr, 32'h8);
`ifdef FETCH_PERF_EN
        chk("perf_stall", bus.stall_count, 32'd5);
        chk("perf_fetch", bus.fetch_count, 32'd2);
`endif
        bus.if_ready = 1'b1;
        step();
        chk("dr_pc4",  bus.if_pc, 32'h4);
        chk("dr_addr", bus.imem_addr, 32'hC);
        step();
        chk("dr_pc8",    bus.if_pc, 32'h8);
        chk("dr_instr8", bus.if_instr, 32'h2003_0032);

        // Redirect to a misaligned target while the queue is full
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h13;
        step();
        bus.redirect_valid = 1'b0;
        chk("rd_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("rd_pc",    bus.if_pc, 32'h0);
        chk("rd_addr",  bus.imem_addr, 32'h10);
        step();
        chk("rd2_pc",    bus.if_pc, 32'h10);
        chk("rd2_instr", bus.if_instr, 32'h0022_0820);
        step();
        chk("rd3_halted", {31'd0, bus.halted}, 32'd1);
        chk("rd3_valid",  {31'd0, bus.if_valid}, 32'd0);

        // PC wrap at the top of the address space
        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFF;
        step();
        bus.redirect_valid = 1'b0;
        chk("wr_halted", {31'd0, bus.halted}, 32'd0);
        chk("wr_addr",   bus.imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wr2_pc",    bus.if_pc, 32'hFFFF_FFFC);
        chk("wr2_instr", bus.if_instr, 32'h3C01_FFFF);
        chk("wr2_addr",  bus.imem_addr, 32'h0);
        step();
        chk("wr3_pc",   bus.if_pc, 32'hFFFF_FFFC);
        chk("wr3_addr", bus.imem_addr, 32'h4);

        // run=0: queue drains, no further fetches
        bus.run      = 1'b0;
        bus.if_ready = 1'b1;
        step();
        chk("st_pc",    bus.if_pc, 32'h0);
        chk("st_instr", bus.if_instr, 32'h2001_000A);
        chk("st_addr",  bus.imem_addr, 32'h4);
        step();
        chk("st2_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("st2_addr",  bus.imem_addr, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
